// File: rtl/fp_addsub_mc.sv
// Multi-cycle IEEE-754 adder/subtractor: one operation in flight, fixed 4-cycle latency,
// FTZ on subnormal inputs, round-to-nearest-even, special values and exception flags.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for operands; captures a, b, op_sub on in_valid
// ALIGN | unpack, flush subnormals, swap, align smaller significand; detect specials
// ADD   | magnitude add or subtract with carry-out
// NORM  | carry shift-right or leading-zero shift-left, exponent adjust
// ROUND | RNE, renormalise, exponent range checks, pack result and flags
// DONE  | result/flags presented and held until out_ready
module fp_addsub_mc #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;       // hidden | mantissa | G | R | S
  localparam int EW  = EXP_W + 2;       // signed exponent with headroom both ways
  localparam int SHW = $clog2(SW);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic                   sub_q, sub_d;
  logic [SW-1:0]          big_q, big_d, small_q, small_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic                   spec_q, spec_d;
  logic [W-1:0]           spec_res_q, spec_res_d;
  logic [3:0]             spec_flg_q, spec_flg_d;
  logic [SW:0]            sum_q, sum_d;
  logic [SW-1:0]          norm_q, norm_d;
  logic                   zero_q, zero_d;
  logic [W-1:0]           result_q, result_d;
  logic [3:0]             flags_q, flags_d;

  // Alignment / special-value decode
  logic                 sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [EXP_W-1:0]     ea, eb, e_big, e_small, diff;
  logic [SW-1:0]        sig_a, sig_b, sig_big, sig_small, small_sh;
  logic [SHW-1:0]       sh;
  logic [W-1:0]         qnan, al_spec_res;
  logic [3:0]           al_spec_flg;
  logic                 al_spec;

  always_comb begin : p_align
    sa      = a_q[W-1];
    sb      = b_q[W-1] ^ sub_q;
    ea      = a_q[W-2:MAN_W];
    eb      = b_q[W-2:MAN_W];
    a_zero  = (ea == '0);
    b_zero  = (eb == '0);
    a_inf   = (ea == EXP_MAX) && (a_q[MAN_W-1:0] == '0);
    b_inf   = (eb == EXP_MAX) && (b_q[MAN_W-1:0] == '0);
    a_nan   = (ea == EXP_MAX) && (a_q[MAN_W-1:0] != '0);
    b_nan   = (eb == EXP_MAX) && (b_q[MAN_W-1:0] != '0);
    sig_a   = a_zero ? '0 : {1'b1, a_q[MAN_W-1:0], 3'b000};
    sig_b   = b_zero ? '0 : {1'b1, b_q[MAN_W-1:0], 3'b000};
    a_big   = {ea, sig_a} >= {eb, sig_b};
    e_big     = a_big ? ea : eb;
    e_small   = a_big ? eb : ea;
    sig_big   = a_big ? sig_a : sig_b;
    sig_small = a_big ? sig_b : sig_a;
    diff      = e_big - e_small;
    sh        = (int'(diff) > SW - 1) ? SHW'(SW - 1) : SHW'(diff);
    // Saturating at SW-1 parks the hidden bit in the sticky position.
    small_sh  = (sig_small >> sh) | SW'(|(sig_small & ~({SW{1'b1}} << sh)));

    qnan                 = '0;
    qnan[W-2:MAN_W]      = '1;
    qnan[MAN_W-1]        = 1'b1;
    al_spec     = 1'b0;
    al_spec_res = '0;
    al_spec_flg = 4'b0000;
    if (a_nan || b_nan) begin
      al_spec     = 1'b1;
      al_spec_res = qnan;
    end else if (a_inf && b_inf && (sa != sb)) begin
      al_spec     = 1'b1;
      al_spec_res = qnan;
      al_spec_flg = 4'b1000;
    end else if (a_inf) begin
      al_spec     = 1'b1;
      al_spec_res = {sa, EXP_MAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      al_spec     = 1'b1;
      al_spec_res = {sb, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

  // Leading-zero count of the uncarried sum
  logic [SHW-1:0] lz;

  always_comb begin : p_lzc
    lz = '0;
    for (int i = 0; i < SW; i++) begin
      if (sum_q[i]) lz = SHW'(SW - 1 - i);
    end
  end

  // Rounding and packing
  logic                 g_bit, r_bit, s_bit, lsb_bit, inexact, inc;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     man_r;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         pack_res;
  logic [3:0]           pack_flg;

  always_comb begin : p_round
    g_bit   = norm_q[2];
    r_bit   = norm_q[1];
    s_bit   = norm_q[0];
    lsb_bit = norm_q[3];
    inexact = g_bit | r_bit | s_bit;
    inc     = g_bit & (r_bit | s_bit | lsb_bit);
    rnd     = {1'b0, norm_q[SW-1:3]} + (MAN_W+2)'(inc);
    man_r   = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    exp_r   = exp_q + $signed(EW'(rnd[MAN_W+1]));
    if (spec_q) begin
      pack_res = spec_res_q;
      pack_flg = spec_flg_q;
    end else if (zero_q) begin
      pack_res = {sign_q, {(W-1){1'b0}}};
      pack_flg = 4'b0000;
    end else if (exp_r >= $signed({2'b00, EXP_MAX})) begin
      pack_res = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
      pack_flg = 4'b0101;
    end else if (exp_r <= 0) begin
      pack_res = {sign_q, {(W-1){1'b0}}};
      pack_flg = 4'b0011;
    end else begin
      pack_res = {sign_q, exp_r[EXP_W-1:0], man_r};
      pack_flg = {3'b000, inexact};
    end
  end

  always_comb begin : p_next
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    big_d      = big_q;
    small_d    = small_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    sum_d      = sum_q;
    norm_d     = norm_q;
    zero_d     = zero_q;
    result_d   = result_q;
    flags_d    = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        big_d      = sig_big;
        small_d    = small_sh;
        exp_d      = $signed(EW'(e_big));
        sign_d     = a_big ? sa : sb;
        eff_sub_d  = sa ^ sb;
        spec_d     = al_spec;
        spec_res_d = al_spec_res;
        spec_flg_d = al_spec_flg;
        state_d    = S_ADD;
      end
      S_ADD: begin
        sum_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                            : ({1'b0, big_q} + {1'b0, small_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        zero_d = 1'b0;
        if (sum_q[SW]) begin
          norm_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + EW'(1);
        end else if (sum_q[SW-1:0] == '0) begin
          // Exact cancellation is +0; only a true add of two -0 keeps the sign.
          zero_d = 1'b1;
          norm_d = '0;
          if (eff_sub_q) sign_d = 1'b0;
        end else begin
          norm_d = sum_q[SW-1:0] << lz;
          exp_d  = exp_q - $signed(EW'(lz));
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = pack_res;
        flags_d  = pack_flg;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      big_q      <= '0;
      small_q    <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
      zero_q     <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      big_q      <= big_d;
      small_q    <= small_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      eff_sub_q  <= eff_sub_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_flg_q <= spec_flg_d;
      sum_q      <= sum_d;
      norm_q     <= norm_d;
      zero_q     <= zero_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_mc.sv
// Directed bench for fp_addsub_mc: expected results queued at issue, compared when out_valid is seen.
module tb_fp_addsub_mc;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];

  fp_addsub_mc #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(op_a), .b(op_b), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic start_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts, input logic [31:0] er, input logic [3:0] ef);
    int n = 0;
    exp_t e;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready_before"}, in_ready, 1);
    op_a = ta; op_b = tb; op_sub = ts; in_valid = 1'b1;
    e.res = er; e.flg = ef;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom);
    chk({tag, "_ready_after_accept"}, in_ready, 0);
  endtask

  task automatic finish_op(input string tag);
    exp_t e;
    int n = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk({tag, "_busy_ready"}, in_ready, 0);
      chk({tag, "_latency_valid"}, out_valid, (i == 4) ? 1 : 0);
    end
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb_q.pop_front();
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_flags"}, flags, 32'(e.flg));
  endtask

  task automatic transfer(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_after_xfer"}, out_valid, 0);
    chk({tag, "_ready_after_xfer"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                     input logic ts, input logic [31:0] er, input logic [3:0] ef);
    start_op(tag, ta, tb, ts, er, ef);
    finish_op(tag);
    transfer(tag);
  endtask

  initial begin
    exp_t dropped;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_in_ready", in_ready, 1);
    #8 rst_n = 1'b1;
    @(posedge clk); #1;

    run("add_basic",  32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4'b0000);
    run("sub_negb",   32'h40400000, 32'hBFC00000, 1'b1, 32'h40900000, 4'b0000);
    run("cancel",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    run("rne_tie_ev", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run("rne_tie_up", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    run("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    run("underflow",  32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    run("nan_in",     32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    run("fin_m_inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    run("negz_negz",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);

    // Backpressure: result held, stray in_valid ignored, accept right after transfer.
    out_ready = 1'b0;
    start_op("hs", 32'h40400000, 32'hBFC00000, 1'b1, 32'h40900000, 4'b0000);
    finish_op("hs");
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      chk("hs_hold_valid", out_valid, 1);
      chk("hs_hold_result", result, 32'h40900000);
      chk("hs_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    transfer("hs");
    run("hs_next", 32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4'b0000);
    run("pre_rst", 32'h40400000, 32'hBFC00000, 1'b1, 32'h40900000, 4'b0000);

    // Reset while the operation sits in ADD.
    start_op("rst_mid", 32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4'b0000);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    dropped = sb_q.pop_back();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_in_ready", in_ready, 1);
    run("post_rst", 32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4'b0000);

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
